// File: rtl/uart_receiver.sv
// uart_receiver: oversampled UART receiver for 8E1 frames.
// The frame is 1 start bit (0), 8 data bits LSB first, 1 even-parity bit and
// 1 stop bit (1). All bit decisions are made on the synchronized line value.
//
// Parameters:
//   OVERSAMPLE     sample_ENABLE ticks per bit period (even, 8..32)
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   sample_ENABLE  one-clk oversampling tick from the baud generator
//   Rx_EN          receiver enable; 0 forces the receiver idle
//   RxD            asynchronous serial input, idle high
//   Rx_DATA        last correctly received byte
//   Rx_VALID       one-clk pulse when a good frame lands in Rx_DATA
//   Rx_PERROR      parity error flag for the last frame
//   Rx_FERROR      framing (stop-bit) error flag for the last frame
module uart_receiver #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_ENABLE,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    localparam int unsigned TCNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BCNT_W = 3;
    localparam logic [TCNT_W-1:0] T_HALF = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] T_LAST = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] B_LAST = BCNT_W'(7);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state;
    logic [TCNT_W-1:0]   tcnt;
    logic [BCNT_W-1:0]   bcnt;
    logic [7:0]          shreg;
    logic                perr_pend;
    logic                sync1;
    logic                rxs;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= RxD;
            rxs   <= sync1;
        end
    end

    // Receive FSM. Counters only move on sample ticks; Rx_EN=0 overrides
    // everything and parks the receiver without touching the outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tcnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            perr_pend <= 1'b0;
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            Rx_VALID <= 1'b0;
            if (!Rx_EN) begin
                state <= IDLE;
                tcnt  <= '0;
                bcnt  <= '0;
            end else if (sample_ENABLE) begin
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            state <= START;
                            tcnt  <= '0;
                        end
                    end
                    // Re-check the line at the middle of the start bit to
                    // reject glitches; a confirmed start clears old errors.
                    START: begin
                        if (tcnt == T_HALF) begin
                            tcnt <= '0;
                            if (rxs) begin
                                state <= IDLE;
                            end else begin
                                Rx_PERROR <= 1'b0;
                                Rx_FERROR <= 1'b0;
                                bcnt      <= '0;
                                state     <= DATA;
                            end
                        end else begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (tcnt == T_LAST) begin
                            tcnt        <= '0;
                            shreg[bcnt] <= rxs;
                            if (bcnt == B_LAST) begin
                                bcnt  <= '0;
                                state <= PARITY;
                            end else begin
                                bcnt <= bcnt + BCNT_W'(1);
                            end
                        end else begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                    // Even parity: received bit must equal XOR of the data.
                    PARITY: begin
                        if (tcnt == T_LAST) begin
                            tcnt      <= '0;
                            perr_pend <= rxs ^ (^shreg);
                            state     <= STOP;
                        end else begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                    STOP: begin
                        if (tcnt == T_LAST) begin
                            tcnt      <= '0;
                            Rx_FERROR <= ~rxs;
                            Rx_PERROR <= perr_pend;
                            if (rxs && !perr_pend) begin
                                Rx_DATA  <= shreg;
                                Rx_VALID <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tcnt  <= '0;
                        bcnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: self-checking bench for uart_receiver (OVERSAMPLE=16,
// sample_ENABLE every 4 clks). Expected outcomes come from a frame-level
// model: parity/stop rules decide flags, good frames update the last byte.
module tb_uart_receiver;

    localparam int unsigned OS       = 16;
    localparam int unsigned TICK_DIV = 4;
    localparam int          BIT_CLKS = OS * TICK_DIV;
    localparam int          SHORT_STOP = 48;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_ENABLE = 1'b0;
    logic       Rx_EN = 1'b1;
    logic       RxD = 1'b1;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    int tests = 0;
    int failed = 0;
    int tick_ph = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_data = 8'h00;
    logic       exp_perr = 1'b0;
    logic       exp_ferr = 1'b0;
    logic [7:0] exp_q[$];

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_ENABLE (sample_ENABLE),
        .Rx_EN         (Rx_EN),
        .RxD           (RxD),
        .Rx_DATA       (Rx_DATA),
        .Rx_VALID      (Rx_VALID),
        .Rx_PERROR     (Rx_PERROR),
        .Rx_FERROR     (Rx_FERROR)
    );

    always #5 clk = ~clk;

    // Baud tick: one clk high every TICK_DIV clks.
    initial begin
        forever begin
            @(negedge clk);
            tick_ph = (tick_ph + 1) % TICK_DIV;
            sample_ENABLE = (tick_ph == 0);
        end
    end

    // Every clk with Rx_VALID high records the byte; a 1-clk pulse gives one entry.
    always @(negedge clk) begin
        if (Rx_VALID === 1'b1) got_q.push_back(Rx_DATA);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one serial frame; stop bit may be shortened.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int stop_clks);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            RxD = f[i];
            idle((i == 10) ? stop_clks : BIT_CLKS);
        end
        RxD = 1'b1;
    endtask

    // Frame-level reference: flags from parity/stop rules, byte only if clean.
    task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        exp_ferr = ~s;
        exp_perr = (int'(p) != (ones % 2));
        if (s && !exp_perr) begin
            exp_data = d;
            exp_q.push_back(d);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle(6);
        #1;
        tests++;
        if ({Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR} !== 11'h000) begin
            failed++;
            $display("FAIL reset_state: got data=%h v=%b pe=%b fe=%b expected all 0",
                     Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR);
        end
        reset = 1'b1;
        idle(2 * BIT_CLKS);
        #1;
        tests++;
        if ({Rx_DATA, Rx_PERROR, Rx_FERROR} !== 10'h000 || got_q.size() != 0) begin
            failed++;
            $display("FAIL reset_release_idle: got data=%h pe=%b fe=%b pulses=%0d expected 0",
                     Rx_DATA, Rx_PERROR, Rx_FERROR, got_q.size());
        end
    endtask

    task automatic test_frame(input string name, input logic [7:0] d, input logic p,
                              input logic s);
        got_q.delete();
        exp_q.delete();
        model_frame(d, p, s);
        send_frame(d, p, s, s ? BIT_CLKS : SHORT_STOP);
        idle(2 * BIT_CLKS);
        #1;
        tests++;
        if ({Rx_DATA, Rx_PERROR, Rx_FERROR} !== {exp_data, exp_perr, exp_ferr}) begin
            failed++;
            $display("FAIL %s_regs: got data=%h pe=%b fe=%b expected data=%h pe=%b fe=%b",
                     name, Rx_DATA, Rx_PERROR, Rx_FERROR, exp_data, exp_perr, exp_ferr);
        end
        tests++;
        if (got_q != exp_q) begin
            failed++;
            $display("FAIL %s_pulse: got %0d pulses %p expected %0d pulses %p",
                     name, got_q.size(), got_q, exp_q.size(), exp_q);
        end
    endtask

    task automatic test_false_start;
        got_q.delete();
        RxD = 1'b0;
        idle(4 * TICK_DIV);
        RxD = 1'b1;
        idle(2 * BIT_CLKS);
        #1;
        tests++;
        if ({Rx_DATA, Rx_PERROR, Rx_FERROR} !== {exp_data, exp_perr, exp_ferr}
            || got_q.size() != 0) begin
            failed++;
            $display("FAIL false_start: got data=%h pe=%b fe=%b pulses=%0d expected data=%h pe=%b fe=%b pulses=0",
                     Rx_DATA, Rx_PERROR, Rx_FERROR, got_q.size(), exp_data, exp_perr, exp_ferr);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [9:0] f;
        got_q.delete();
        f = {1'b0, 8'h55, 1'b0};
        // Start bit plus data bits 0..2, then halfway into data bit 3.
        for (int i = 0; i < 4; i++) begin
            RxD = f[i];
            idle(BIT_CLKS);
        end
        RxD = f[4];
        idle(BIT_CLKS / 2);
        reset = 1'b0;
        #1;
        exp_data = 8'h00;
        exp_perr = 1'b0;
        exp_ferr = 1'b0;
        tests++;
        if ({Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR} !== 11'h000) begin
            failed++;
            $display("FAIL reset_mid_frame: got data=%h v=%b pe=%b fe=%b expected all 0",
                     Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR);
        end
        idle(8);
        RxD = 1'b1;
        idle(4);
        reset = 1'b1;
        idle(2 * BIT_CLKS);
        test_frame("after_reset_55", 8'h55, 1'b0, 1'b1);
    endtask

    task automatic test_rx_en_abort;
        logic [10:0] f;
        got_q.delete();
        f = {1'b1, 1'b0, 8'h66, 1'b0};
        for (int i = 0; i < 9; i++) begin
            RxD = f[i];
            idle(BIT_CLKS);
        end
        RxD = f[9];
        idle(8);
        Rx_EN = 1'b0;
        idle(BIT_CLKS - 8);
        RxD = f[10];
        idle(BIT_CLKS);
        RxD = 1'b1;
        idle(16);
        Rx_EN = 1'b1;
        idle(BIT_CLKS);
        #1;
        tests++;
        if ({Rx_DATA, Rx_PERROR, Rx_FERROR} !== {exp_data, exp_perr, exp_ferr}
            || got_q.size() != 0) begin
            failed++;
            $display("FAIL rx_en_abort: got data=%h pe=%b fe=%b pulses=%0d expected data=%h pe=%b fe=%b pulses=0",
                     Rx_DATA, Rx_PERROR, Rx_FERROR, got_q.size(), exp_data, exp_perr, exp_ferr);
        end
    endtask

    task automatic test_back_to_back;
        got_q.delete();
        exp_q.delete();
        model_frame(8'h12, 1'b0, 1'b1);
        model_frame(8'h34, 1'b1, 1'b1);
        send_frame(8'h12, 1'b0, 1'b1, BIT_CLKS);
        send_frame(8'h34, 1'b1, 1'b1, BIT_CLKS);
        idle(2 * BIT_CLKS);
        #1;
        tests++;
        if (got_q != exp_q) begin
            failed++;
            $display("FAIL back_to_back_pulses: got %0d pulses %p expected %0d pulses %p",
                     got_q.size(), got_q, exp_q.size(), exp_q);
        end
        tests++;
        if ({Rx_DATA, Rx_PERROR, Rx_FERROR} !== {exp_data, exp_perr, exp_ferr}) begin
            failed++;
            $display("FAIL back_to_back_regs: got data=%h pe=%b fe=%b expected data=%h pe=%b fe=%b",
                     Rx_DATA, Rx_PERROR, Rx_FERROR, exp_data, exp_perr, exp_ferr);
        end
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic       p;
        logic       s;
        for (int n = 0; n < 12; n++) begin
            d = 8'($urandom);
            p = (^d) ^ ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 4) != 0);
            test_frame("random", d, p, s);
        end
    endtask

    initial begin
        test_reset;
        test_frame("good_a5", 8'hA5, 1'b0, 1'b1);
        test_frame("parity_3c", 8'h3C, 1'b1, 1'b1);
        test_false_start;
        test_frame("framing_01", 8'h01, 1'b1, 1'b0);
        test_frame("good_7e", 8'h7E, 1'b0, 1'b1);
        test_reset_mid_frame;
        test_rx_en_abort;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter: OVERSAMPLE, 16, number of sample_ENABLE ticks per bit period (even, 8..32).
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port: sample_ENABLE  input  1  one-clk oversampling tick from the baud tick generator.
REQ-005 SHALL have port: Rx_EN  input  1  receiver enable; 0 = receiver idle.
REQ-006 SHALL have port: RxD  input  1  asynchronous serial line; idle high.
REQ-007 SHALL have port: Rx_DATA  output  8  last correctly received byte.
REQ-008 SHALL have port: Rx_VALID  output  1  one-clk pulse when a good frame lands in Rx_DATA.
REQ-009 SHALL have port: Rx_PERROR  output  1  parity error flag for the last frame.
REQ-010 SHALL have port: Rx_FERROR  output  1  framing (stop-bit) error flag for the last frame.

Function
REQ-011 SHALL pass RxD through a 2-flop synchronizer (flops reset to 1); all decisions use the synchronized value rxs.
REQ-012 SHALL use frame format: 1 start (0), 8 data LSB first, 1 even-parity bit, 1 stop (1).
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; tick counter tcnt 0..OVERSAMPLE-1, bit counter bcnt 0..7.
REQ-014 SHALL advance tcnt and sample only on clk edges where sample_ENABLE=1; all other edges hold state.
REQ-015 SHALL leave IDLE for START, with tcnt=0, on a tick where Rx_EN=1 and rxs=0.
REQ-016 SHALL treat START as follows: at tcnt=OVERSAMPLE/2-1, rxs=1 -> false start, back to IDLE, no flag change; rxs=0 -> clear both error flags, tcnt=0, go to DATA.
REQ-017 SHALL treat DATA/PARITY/STOP as follows: sample rxs when tcnt=OVERSAMPLE-1 (bit centre), then reset tcnt to 0.
REQ-018 SHALL shift samples in DATA into bit bcnt of a shift register; after bcnt=7 go to PARITY.
REQ-019 SHALL, in PARITY, set parity-error pending when the sampled bit != XOR of the 8 data bits; then go to STOP.
REQ-020 SHALL, in STOP at the sample tick: stop=0 -> Rx_FERROR=1; Rx_PERROR=pending; FSM returns to IDLE on the same edge.
REQ-021 SHALL, in STOP with stop=1 and no parity error, load Rx_DATA from the shift register and pulse Rx_VALID for exactly that one clk.
REQ-022 SHALL keep Rx_DATA unchanged on any errored, false-start or aborted frame; error flags hold until the next valid start (REQ-016).
REQ-023 SHALL set Rx_VALID=0 when either error flag is set in the same frame.
REQ-024 SHALL, when Rx_EN=0 in any state, return to IDLE on the next clk edge, clear tcnt/bcnt, leave outputs unchanged, and generate no pulse.
REQ-025 SHALL allow back-to-back frames: start detection is permitted on the first tick after STOP completes.

Reset
REQ-026 SHALL, while reset=0: FSM=IDLE, tcnt=bcnt=0, synchronizer flops=1, Rx_DATA=8'h00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0.
REQ-027 SHALL, on reset assertion mid-frame, abort the frame immediately; the first frame after release is received normally.

Verification
REQ-028 SHALL check: OVERSAMPLE=16, sample_ENABLE every 4 clks, frame 0xA5 with parity 0 and stop 1 -> Rx_DATA=8'hA5, Rx_VALID high 1 clk, both errors 0.
REQ-029 SHALL check: frame 0x3C with parity 1 -> Rx_PERROR=1, Rx_FERROR=0, no Rx_VALID, Rx_DATA keeps previous 8'hA5.
REQ-030 SHALL check: frame 0x01 with parity 1 and stop 0 -> Rx_FERROR=1, Rx_PERROR=0, no Rx_VALID; next good frame 0x7E clears both flags and sets Rx_DATA=8'h7E.
REQ-031 SHALL check: RxD low for 4 ticks then high -> FSM back to IDLE, no flag or data change.
REQ-032 SHALL check: reset=0 during DATA bit 3 -> all outputs 0 at once; after release, frame 0x55 is received with Rx_VALID.
REQ-033 SHALL check: Rx_EN=0 during PARITY -> no pulse, IDLE next clk; two back-to-back frames 0x12 and 0x34 -> two Rx_VALID pulses in order.
